// File: rtl/mem_bus_master.sv
// Single-outstanding memory bus master: CPU request -> shared-bus access -> one-cycle response.
// Optional access timeout is compiled in with `define MEM_BUS_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module mem_bus_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic       mem_run,
    output logic       mem_rw,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    inout  wire  [7:0] uniBus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state_q, state_d;
    logic       rw_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q, rdata_d;
    logic       accept;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             expired;

    // The edge that completes the TIMEOUT_CYCLES-th silent ACCESS cycle aborts the access.
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign accept = (state_q == IDLE) && req_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ACCESS;
`ifdef MEM_BUS_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = RESP;
                    if (rw_q) begin
                        rdata_d = uniBus;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (expired) begin
                    state_d = RESP;
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdata_q <= 8'h00;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            rdata_q <= rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Request fields are only observed while ACCESS is active, so they need no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_run    = (state_q == ACCESS);
    assign mem_rw     = (state_q == ACCESS) ? rw_q : 1'b0;
    assign mem_addr   = (state_q == ACCESS) ? addr_q : 8'h00;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign uniBus     = ((state_q == ACCESS) && !rw_q) ? wdata_q : 'z;

`ifdef MEM_BUS_TIMEOUT_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
